// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready handshakes.
// Define CSEL_ADDER_SAT_EN to saturate the sum on signed overflow.
module csel_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NBLK = WIDTH / BLOCK;
    localparam int SPS  = NBLK / STAGES;
    localparam int SW   = SPS * BLOCK;

    logic             adv;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    genvar s;
    generate
        for (s = 0; s < STAGES; s++) begin : g_stg
            localparam int LO = s * SW;
            localparam int HI = LO + SW;

            // x carries finished sum bits below LO and raw A bits above
            logic             v_in;
            logic [WIDTH-1:0] x_in;
            logic [WIDTH-1:LO] bp_in;
            logic             c_in;
            logic [WIDTH-1:0] x_d;
            logic             c_d;

            if (s == 0) begin : g_src
                assign v_in  = in_valid;
                assign x_in  = a;
                assign bp_in = sub ? ~b : b;
                assign c_in  = sub | cin;
            end else begin : g_src
                assign v_in  = g_stg[s-1].g_reg.v_q;
                assign x_in  = g_stg[s-1].g_reg.x_q;
                assign bp_in = g_stg[s-1].g_reg.bp_q;
                assign c_in  = g_stg[s-1].g_reg.c_q;
            end

            always_comb begin
                logic             c;
                logic [BLOCK-1:0] as;
                logic [BLOCK-1:0] bs;
                logic [BLOCK:0]   r0;
                logic [BLOCK:0]   r1;
                logic [BLOCK:0]   rs;
                x_d = x_in;
                c   = c_in;
                as  = '0;
                bs  = '0;
                r0  = '0;
                r1  = '0;
                rs  = '0;
                for (int j = 0; j < SPS; j++) begin
                    as = x_in[LO+j*BLOCK +: BLOCK];
                    bs = bp_in[LO+j*BLOCK +: BLOCK];
                    r0 = {1'b0, as} + {1'b0, bs};
                    r1 = {1'b0, as} + {1'b0, bs}
                       + {{BLOCK{1'b0}}, 1'b1};
                    rs = c ? r1 : r0;
                    x_d[LO+j*BLOCK +: BLOCK] = rs[BLOCK-1:0];
                    c = rs[BLOCK];
                end
                c_d = c;
            end

            if (s < STAGES - 1) begin : g_reg
                logic              v_q;
                logic [WIDTH-1:0]  x_q;
                logic [WIDTH-1:HI] bp_q;
                logic              c_q;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        v_q  <= 1'b0;
                        x_q  <= '0;
                        bp_q <= '0;
                        c_q  <= 1'b0;
                    end else if (adv) begin
                        v_q  <= v_in;
                        x_q  <= x_d;
                        bp_q <= bp_in[WIDTH-1:HI];
                        c_q  <= c_d;
                    end
                end
            end
        end
    endgenerate

    logic             last_v;
    logic             a_msb;
    logic             bp_msb;
    logic [WIDTH-1:0] raw_sum;
    logic             cout_d;
    logic             ovf_d;
    logic [WIDTH-1:0] sum_d;

    assign last_v  = g_stg[STAGES-1].v_in;
    assign a_msb   = g_stg[STAGES-1].x_in[WIDTH-1];
    assign bp_msb  = g_stg[STAGES-1].bp_in[WIDTH-1];
    assign raw_sum = g_stg[STAGES-1].x_d;
    assign cout_d  = g_stg[STAGES-1].c_d;

    always_comb begin
        ovf_d = (a_msb == bp_msb) && (raw_sum[WIDTH-1] != a_msb);
`ifdef CSEL_ADDER_SAT_EN
        sum_d = raw_sum;
        if (ovf_d) begin
            sum_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                          : {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
        sum_d = raw_sum;
`endif
    end

    // Result fields only load on a valid op so bubbles leave them untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= last_v;
            if (last_v) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed and random checks of csel_adder_pipe against an arithmetic model.
module tb_csel_adder_pipe;

    localparam int W  = 32;
    localparam int ST = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic          cout;
    logic          overflow;

    csel_adder_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(ST)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           cyc;
        int           st;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   stalls = 0;
    int   n_emit = 0;
    exp_t q[$];

    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_sum;
    logic         prev_co;
    logic         prev_ov;

    task automatic check(string nm, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    function automatic exp_t model(logic [W-1:0] av, logic [W-1:0] bv,
                                   logic ci, logic sb);
        exp_t         e;
        logic [W-1:0] be;
        logic         c;
        longint       ur;
        longint       sr;
        longint       sa;
        longint       sbb;
        be  = sb ? ~bv : bv;
        c   = sb ? 1'b1 : ci;
        ur  = longint'({32'b0, av}) + longint'({32'b0, be}) + longint'(c);
        sa  = $signed(av);
        sbb = $signed(be);
        sr  = sa + sbb + longint'(c);
        e.s  = ur[W-1:0];
        e.co = ur[W];
        e.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef CSEL_ADDER_SAT_EN
        if (e.ov) e.s = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        e.cyc = 0;
        e.st  = 0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", {63'b0, out_valid}, 64'd1);
                check("hold_data", {31'b0, sum, cout, overflow},
                      {31'b0, prev_sum, prev_co, prev_ov});
            end
            check("in_ready_rule", {63'b0, in_ready},
                  {63'b0, (!out_valid || out_ready)});
            if (out_valid && out_ready) begin
                n_emit++;
                if (q.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("res_sum", {32'b0, sum}, {32'b0, e.s});
                    check("res_flags", {62'b0, cout, overflow},
                          {62'b0, e.co, e.ov});
                    check("latency", 64'(cyc),
                          64'(e.cyc + ST + (stalls - e.st)));
                end
            end
            if (out_valid && !out_ready) stalls++;
            if (in_valid && in_ready) begin
                e = model(a, b, cin, sub);
                e.cyc = cyc;
                e.st  = stalls;
                q.push_back(e);
            end
            prev_hold = out_valid && !out_ready;
            prev_sum  = sum;
            prev_co   = cout;
            prev_ov   = overflow;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(string nm, logic [W-1:0] av, logic [W-1:0] bv,
                           logic ci, logic sb, logic [W-1:0] es,
                           logic ec, logic eo);
        int found;
        int lat;
        a = av; b = bv; cin = ci; sub = sb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'b1; sub = 1'b0;
        found = 0;
        lat = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1;
                lat = t;
                break;
            end
        end
        if (found == 0) begin
            check({nm, "_timeout"}, 64'd1, 64'd0);
        end else begin
            check({nm, "_sum"}, {32'b0, sum}, {32'b0, es});
            check({nm, "_cout"}, {63'b0, cout}, {63'b0, ec});
            check({nm, "_ovf"}, {63'b0, overflow}, {63'b0, eo});
            check({nm, "_lat"}, 64'(lat), 64'(ST - 1));
        end
        step();
    endtask

    initial begin
        int base;
        int ok;
        int sel;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_data", {31'b0, sum, cout, overflow}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        step();

        run_one("t1_add", 32'h5, 32'h3, 1'b1, 1'b0, 32'h9, 1'b0, 1'b0);
        run_one("t2_chain", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0,
                32'h0, 1'b1, 1'b0);
        run_one("mid_chain", 32'h0000_FFFF, 32'h0, 1'b1, 1'b0,
                32'h0001_0000, 1'b0, 1'b0);
`ifdef CSEL_ADDER_SAT_EN
        run_one("t3_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
                32'h7FFF_FFFF, 1'b0, 1'b1);
`else
        run_one("t3_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
                32'h8000_0000, 1'b0, 1'b1);
`endif
        run_one("t4_sub", 32'h0, 32'h1, 1'b0, 1'b1,
                32'hFFFF_FFFF, 1'b0, 1'b0);
`ifdef CSEL_ADDER_SAT_EN
        run_one("t4_subovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1,
                32'h8000_0000, 1'b1, 1'b1);
`else
        run_one("t4_subovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1,
                32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
        run_one("sub_cin_ign", 32'd10, 32'd3, 1'b0, 1'b1,
                32'd7, 1'b1, 1'b0);

        // T5: six ops with the consumer stalled mid-burst
        base = n_emit;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    a = 32'h1111_1111 * i;
                    b = 32'h1000_0000 + i;
                    sub = i[0];
                    cin = i[1];
                    in_valid = 1'b1;
                    ok = 0;
                    for (int t = 0; t < 50 && ok == 0; t++) begin
                        @(negedge clk);
                        if (in_ready) ok = 1;
                        step();
                    end
                    if (ok == 0) check("t5_accept", 64'd0, 64'd1);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) step();
                out_ready = 1'b0;
                repeat (4) step();
                out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 60 && n_emit < base + 6; t++) step();
        check("t5_count", 64'(n_emit - base), 64'd6);

        // T6: reset lands while an op is in flight
        a = 32'h1234; b = 32'h1; sub = 1'b0; cin = 1'b0;
        in_valid = 1'b1;
        step();
        a = 32'h5678;
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        for (int t = 0; t < ST + 3; t++) begin
            @(negedge clk);
            check("t6_no_valid", {63'b0, out_valid}, 64'd0);
        end
        check("t6_zero", {31'b0, sum, cout, overflow}, 64'd0);
        step();

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            sel = $urandom % 5;
            a = (sel == 0) ? 32'h7FFF_FFFF :
                (sel == 1) ? 32'h8000_0000 :
                (sel == 2) ? 32'hFFFF_FFFF : $urandom;
            b = (sel == 3) ? 32'h0000_0001 : $urandom;
            cin = $urandom % 2;
            sub = $urandom % 2;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (ST + 4) step();
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
